// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared definitions for the counter command sequencer: mode encodings, FSM
// states and command-word layout {mode, D, len, stop_on_rco}.
package counter_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam logic [1:0] MODE_00 = 2'b00;
  localparam logic [1:0] MODE_01 = 2'b01;
  localparam logic [1:0] MODE_10 = 2'b10;
  localparam logic [1:0] MODE_11 = 2'b11;

  // Field offsets, LSB first: stop_on_rco, len, D, mode
  localparam int unsigned STOP_OFS = 0;
  localparam int unsigned LEN_OFS  = 1;

  function automatic int unsigned cmd_w(input int unsigned data_w, input int unsigned len_w);
    return 2 + data_w + len_w + 1;
  endfunction

  function automatic int unsigned d_ofs(input int unsigned len_w);
    return LEN_OFS + len_w;
  endfunction

  function automatic int unsigned mode_ofs(input int unsigned data_w, input int unsigned len_w);
    return LEN_OFS + len_w + data_w;
  endfunction

endpackage

// File: rtl/counter_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read data, sync reset and flush.
module cmd_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Turns queued {mode, D, len, stop_on_rco} commands into counter enable/mode/D.
// Optional macro SEQ_CMD_COUNT_EN adds a saturating completed-command counter.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [DATA_W-1:0] cmd_d,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_stop_rco,
  input  logic              abort,
  input  logic              rco,
  output logic              enable,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        cmd_count
);
  localparam int unsigned CMD_W = cmd_w(DATA_W, LEN_W);
  localparam int unsigned D_OFS = d_ofs(LEN_W);
  localparam int unsigned M_OFS = mode_ofs(DATA_W, LEN_W);

  seq_state_t        state;
  logic [LEN_W-1:0]  rem;
  logic              stop_q;
  logic [CMD_W-1:0]  cmd_word;
  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              term;
  logic [1:0]        head_mode;
  logic [DATA_W-1:0] head_d;
  logic [LEN_W-1:0]  head_len;
  logic              head_stop;

  assign cmd_word  = {cmd_mode, cmd_d, cmd_len, cmd_stop_rco};
  assign head_mode = head[M_OFS +: 2];
  assign head_d    = head[D_OFS +: DATA_W];
  assign head_len  = head[LEN_OFS +: LEN_W];
  assign head_stop = head[STOP_OFS];

  assign cmd_ready = !fifo_full && !abort;
  assign push      = cmd_valid && cmd_ready && !reset;

  always_comb begin
    term = (state == ST_RUN) && ((rem == LEN_W'(1)) || (stop_q && rco));
    pop  = !reset && !abort && !fifo_empty && ((state == ST_IDLE) || term);
  end

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_word),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rem    <= '0;
      stop_q <= 1'b0;
      enable <= 1'b0;
      busy   <= 1'b0;
      mode   <= '0;
      D      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (state == ST_RUN) begin
          if (term) begin
            done   <= 1'b1;
            state  <= ST_IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        // A pop on termination overrides the fall to IDLE, giving back-to-back runs
        if (pop) begin
          mode   <= head_mode;
          D      <= head_d;
          stop_q <= head_stop;
          rem    <= head_len;
          if (head_len == '0) begin
            err    <= 1'b1;
            state  <= ST_IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else begin
            state  <= ST_RUN;
            enable <= 1'b1;
            busy   <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEQ_CMD_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (term && !abort && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign cmd_count = count_q;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_counter_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_d;
  logic [7:0] cmd_len;
  logic       cmd_stop_rco;
  logic       abort;
  logic       rco;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] D;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] cmd_count;

  counter_cmd_sequencer #(
    .DATA_W     (4),
    .LEN_W      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_d        (cmd_d),
    .cmd_len      (cmd_len),
    .cmd_stop_rco (cmd_stop_rco),
    .abort        (abort),
    .rco          (rco),
    .enable       (enable),
    .mode         (mode),
    .D            (D),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cmd_count    (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [3:0] d;
    logic [7:0] len;
    logic       s;
  } cmd_t;

  cmd_t       q[$];
  bit         running;
  int         left;
  bit         cur_stop;
  logic       exp_en, exp_busy, exp_done, exp_err;
  logic [1:0] exp_mode;
  logic [3:0] exp_d;
  int         exp_cnt;
  bit         started;
  int         n_cmp;
  int         n_bad;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Advances the model by one clock edge using the inputs sampled at that edge
  function automatic void model_step();
    cmd_t c;
    bit   push_ok;
    push_ok = cmd_valid && (q.size() < 4) && !abort;
    if (reset) begin
      q.delete();
      running = 0; left = 0; cur_stop = 0;
      exp_mode = '0; exp_d = '0; exp_done = 0; exp_err = 0; exp_cnt = 0;
    end else begin
      exp_done = 0;
      exp_err  = 0;
      if (abort) begin
        q.delete();
        running = 0;
      end else begin
        if (running) begin
          if (left == 1 || (cur_stop && rco)) begin
            exp_done = 1;
            running  = 0;
`ifdef SEQ_CMD_COUNT_EN
            if (exp_cnt < 255) exp_cnt++;
`endif
          end else begin
            left--;
          end
        end
        if (!running && q.size() > 0) begin
          c = q.pop_front();
          exp_mode = c.m;
          exp_d    = c.d;
          if (c.len == 0) exp_err = 1;
          else begin
            running  = 1;
            left     = int'(c.len);
            cur_stop = c.s;
          end
        end
        if (push_ok) begin
          c.m = cmd_mode; c.d = cmd_d; c.len = cmd_len; c.s = cmd_stop_rco;
          q.push_back(c);
        end
      end
    end
    exp_en   = running;
    exp_busy = running;
  endfunction

  task automatic tick();
    #1;
    if (started) chk("cmd_ready", 32'(cmd_ready), 32'((q.size() < 4) && !abort));
    @(posedge clk);
    model_step();
    started = 1;
    #1;
    chk("enable", 32'(enable), 32'(exp_en));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    chk("mode", 32'(mode), 32'(exp_mode));
    chk("D", 32'(D), 32'(exp_d));
    chk("cmd_count", 32'(cmd_count), 32'(exp_cnt));
  endtask

  task automatic set_cmd(input logic [1:0] m, input logic [3:0] d, input logic [7:0] len, input logic s);
    cmd_valid = 1'b1; cmd_mode = m; cmd_d = d; cmd_len = len; cmd_stop_rco = s;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; abort = 1'b0; rco = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int en_sum, done_sum, first_en, last_en;

  initial begin
    n_cmp = 0; n_bad = 0; started = 0;
    q.delete(); running = 0; left = 0; cur_stop = 0; exp_cnt = 0;
    idle_inputs();
    cmd_mode = '0; cmd_d = '0; cmd_len = '0; cmd_stop_rco = 1'b0;

    // Reset state
    do_reset();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_count", 32'(cmd_count), 32'd0);

    // T1: single len=3 command
    set_cmd(2'b01, 4'h5, 8'd3, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("T1_en_after_push", 32'(enable), 32'd0);
    tick();
    chk("T1_en_start", 32'(enable), 32'd1);
    chk("T1_mode", 32'(mode), 32'd1);
    chk("T1_D", 32'(D), 32'h5);
    tick();
    tick();
    chk("T1_en_third", 32'(enable), 32'd1);
    chk("T1_no_early_done", 32'(done), 32'd0);
    tick();
    chk("T1_en_off", 32'(enable), 32'd0);
    chk("T1_done", 32'(done), 32'd1);
    tick();
    chk("T1_done_pulse", 32'(done), 32'd0);

    // T2: len=2 then len=4 back to back
    en_sum = 0; done_sum = 0; first_en = -1; last_en = -1;
    set_cmd(2'b10, 4'hA, 8'd2, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) set_cmd(2'b11, 4'h3, 8'd4, 1'b0);
      else cmd_valid = 1'b0;
      if (i == 4) chk("T2_switch_mode", 32'(mode), 32'd3);
      en_sum += int'(enable);
      done_sum += int'(done);
      if (enable && first_en < 0) first_en = i;
      if (enable) last_en = i;
    end
    chk("T2_en_cycles", 32'(en_sum), 32'd6);
    chk("T2_first_en", 32'(first_en), 32'd2);
    chk("T2_last_en", 32'(last_en), 32'd7);
    chk("T2_dones", 32'(done_sum), 32'd2);

    // T3: long command ended by rco on its 5th run cycle
    set_cmd(2'b00, 4'h7, 8'hFF, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("T3_en_cycle5", 32'(enable), 32'd1);
    rco = 1'b1;
    tick();
    chk("T3_en_drop", 32'(enable), 32'd0);
    chk("T3_done", 32'(done), 32'd1);
    tick();
    chk("T3_rco_ignored", 32'(done), 32'd0);
    rco = 1'b0;

    // T5: illegal len=0 then len=1
    set_cmd(2'b01, 4'h1, 8'd0, 1'b0);
    tick();
    set_cmd(2'b10, 4'h2, 8'd1, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("T5_err", 32'(err), 32'd1);
    chk("T5_no_en", 32'(enable), 32'd0);
    tick();
    chk("T5_en", 32'(enable), 32'd1);
    chk("T5_err_pulse", 32'(err), 32'd0);
    tick();
    chk("T5_done", 32'(done), 32'd1);
    chk("T5_en_off", 32'(enable), 32'd0);

    // T4: fill the FIFO behind a stalled command
    set_cmd(2'b11, 4'hF, 8'hFF, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_cmd(2'(i), 4'(i + 8), 8'd3, 1'b0);
      tick();
    end
    #1;
    chk("T4_ready_full", 32'(cmd_ready), 32'd0);
    tick();
    rco = 1'b1;
    tick();
    rco = 1'b0;
    #1;
    chk("T4_ready_after_pop", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;

    // T6: abort mid-run with commands queued
    tick();
    chk("T6_pre_en", 32'(enable), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("T6_en", 32'(enable), 32'd0);
    chk("T6_no_done", 32'(done), 32'd0);
    tick();
    chk("T6_flushed", 32'(enable), 32'd0);

    // Reset mid-run
    set_cmd(2'b10, 4'h9, 8'd20, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("RST_en", 32'(enable), 32'd0);
    chk("RST_busy", 32'(busy), 32'd0);
    chk("RST_D", 32'(D), 32'd0);
    chk("RST_count", 32'(cmd_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      reset        = ($urandom_range(0, 299) == 0);
      abort        = ($urandom_range(0, 59) == 0);
      cmd_valid    = 1'($urandom_range(0, 1));
      cmd_mode     = 2'($urandom);
      cmd_d        = 4'($urandom);
      cmd_stop_rco = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 15);
      if (r == 0) cmd_len = 8'd0;
      else if (r <= 12) cmd_len = 8'($urandom_range(1, 6));
      else if (r <= 14) cmd_len = 8'($urandom_range(7, 40));
      else begin
        cmd_len = 8'hFF;
        cmd_stop_rco = 1'b1;
      end
      rco = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
